// File: rtl/reg_dump_reader.sv
`default_nettype none
// ============================================================================
// Module   : reg_dump_reader
// Purpose  : Sequential readback engine for a register bank. Walks a select
//            index over NUM_REGS registers, samples each selected word and
//            streams it out on a valid/ready handshake tagged with its index.
//            Used for debug dumps without disturbing datapath writes.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports:
//   clock      in   system clock, rising edge
//   clear      in   asynchronous active-high reset
//   start      in   request a dump pass (only honoured when idle)
//   abort      in   synchronous cancel of an active pass
//   reg_sel    out  index driven to the register read mux
//   reg_data   in   selected register word (combinational from reg_sel)
//   out_data   out  sampled register word
//   out_index  out  index of out_data
//   out_valid  out  out_data/out_index/out_last are valid
//   out_ready  in   sink accepts the word
//   out_last   out  word belongs to index NUM_REGS-1
//   busy       out  engine is not idle
//   done       out  one-cycle pulse when a full pass completes
// ============================================================================
module reg_dump_reader #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REGS   = 16,
  parameter int SEL_WIDTH  = 4
) (
  input  logic                  clock,
  input  logic                  clear,
  input  logic                  start,
  input  logic                  abort,
  output logic [SEL_WIDTH-1:0]  reg_sel,
  input  logic [DATA_WIDTH-1:0] reg_data,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [SEL_WIDTH-1:0]  out_index,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  out_last,
  output logic                  busy,
  output logic                  done
);

  localparam logic [SEL_WIDTH-1:0] c_LAST_IDX = SEL_WIDTH'(NUM_REGS - 1);
  localparam logic [SEL_WIDTH-1:0] c_IDX_ONE  = SEL_WIDTH'(1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_READ = 2'd1,
    S_HOLD = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t                r_state;
  logic [SEL_WIDTH-1:0]  r_idx;
  logic [SEL_WIDTH-1:0]  r_reg_sel;
  logic [DATA_WIDTH-1:0] r_out_data;
  logic [SEL_WIDTH-1:0]  r_out_index;
  logic                  r_out_valid;
  logic                  r_out_last;
  logic                  r_busy;
  logic                  r_done;

  // All outputs are registered; reg_sel is loaded one edge ahead of READ so
  // the mux output is settled when READ samples it.
  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      r_state     <= S_IDLE;
      r_idx       <= '0;
      r_reg_sel   <= '0;
      r_out_data  <= '0;
      r_out_index <= '0;
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          // abort is meaningless here, so start simply wins
          if (start) begin
            r_state   <= S_READ;
            r_idx     <= '0;
            r_reg_sel <= '0;
            r_busy    <= 1'b1;
          end
        end

        S_READ: begin
          if (abort) begin
            r_state     <= S_IDLE;
            r_idx       <= '0;
            r_reg_sel   <= '0;
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
            r_busy      <= 1'b0;
          end else begin
            // Capture happens on this edge: a register write landing on the
            // same edge is not yet visible on reg_data, so the old value wins.
            r_out_data  <= reg_data;
            r_out_index <= r_idx;
            r_out_last  <= (r_idx == c_LAST_IDX);
            r_out_valid <= 1'b1;
            r_state     <= S_HOLD;
          end
        end

        S_HOLD: begin
          // abort takes priority over a handshake in the same cycle
          if (abort) begin
            r_state     <= S_IDLE;
            r_idx       <= '0;
            r_reg_sel   <= '0;
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
            r_busy      <= 1'b0;
          end else if (out_ready) begin
            r_out_valid <= 1'b0;
            if (r_idx == c_LAST_IDX) begin
              r_out_last <= 1'b0;
              r_reg_sel  <= '0;
              r_done     <= 1'b1;
              r_state    <= S_DONE;
            end else begin
              r_idx     <= r_idx + c_IDX_ONE;
              r_reg_sel <= r_idx + c_IDX_ONE;
              r_state   <= S_READ;
            end
          end
        end

        S_DONE: begin
          r_state   <= S_IDLE;
          r_idx     <= '0;
          r_reg_sel <= '0;
          r_busy    <= 1'b0;
          if (abort) begin
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
          end
        end

        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign reg_sel   = r_reg_sel;
  assign out_data  = r_out_data;
  assign out_index = r_out_index;
  assign out_valid = r_out_valid;
  assign out_last  = r_out_last;
  assign busy      = r_busy;
  assign done      = r_done;

endmodule
`default_nettype wire

// File: tb/tb_reg_dump_reader.sv
`default_nettype none
// ============================================================================
// Module   : tb_reg_dump_reader
// Purpose  : Self-checking bench for reg_dump_reader. A register bank array
//            feeds reg_data; expected streams come from snapshots of that
//            array and simple cycle arithmetic (2 cycles/word + 1 per stall).
// Revision : 1.0 - initial release
// ============================================================================
module tb_reg_dump_reader;

  localparam int DW = 32;
  localparam int NR = 16;
  localparam int SW = 4;

  logic          clock = 1'b0;
  logic          clear;
  logic          start;
  logic          abort;
  logic [SW-1:0] reg_sel;
  logic [DW-1:0] reg_data;
  logic [DW-1:0] out_data;
  logic [SW-1:0] out_index;
  logic          out_valid;
  logic          out_ready;
  logic          out_last;
  logic          busy;
  logic          done;

  logic [DW-1:0] regs [NR];
  assign reg_data = regs[reg_sel];

  always #5 clock = ~clock;

  reg_dump_reader #(.DATA_WIDTH(DW), .NUM_REGS(NR), .SEL_WIDTH(SW)) dut (
    .clock     (clock),
    .clear     (clear),
    .start     (start),
    .abort     (abort),
    .reg_sel   (reg_sel),
    .reg_data  (reg_data),
    .out_data  (out_data),
    .out_index (out_index),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_last  (out_last),
    .busy      (busy),
    .done      (done)
  );

  int checks   = 0;
  int failures = 0;

  // Observations gathered by run_pass (no judgement made there)
  logic [DW-1:0] acc_data [$];
  logic [SW-1:0] acc_idx  [$];
  logic          acc_last [$];
  logic [DW-1:0] snap [NR];
  int n_done, done_at, n_stall, n_unstable, n_busy_low, busy_after;
  bit timed_out;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Starts one pass and records what the sink sees until the cycle after done.
  task automatic run_pass(input int stall_idx, input int stall_len, input bit rand_rdy,
                          input int wr_idx, input logic [DW-1:0] wr_val, input bit spam_start);
    int held = 0;
    bit pv = 1'b0;
    bit pr = 1'b0;
    logic [DW-1:0] pd = '0;
    logic [SW-1:0] pi = '0;
    logic pl = 1'b0;
    acc_data.delete(); acc_idx.delete(); acc_last.delete();
    n_done = 0; done_at = -1; n_stall = 0; n_unstable = 0; n_busy_low = 0;
    busy_after = -1; timed_out = 1'b1;
    for (int i = 0; i < NR; i++) snap[i] = regs[i];
    start = 1'b1; abort = 1'b0; out_ready = 1'b0;
    step();
    start = 1'b0;
    for (int t = 0; t < 400; t++) begin
      if (done_at >= 0) begin
        busy_after = int'(busy);
        timed_out  = 1'b0;
        break;
      end
      if (done) begin
        n_done++;
        done_at = t;
      end
      if (!busy) n_busy_low++;
      if (pv && !pr) begin
        if (!out_valid || out_data !== pd || out_index !== pi || out_last !== pl) n_unstable++;
      end
      if (out_valid) begin
        if (int'(out_index) == stall_idx && held < stall_len) begin
          out_ready = 1'b0;
          held++;
        end else begin
          out_ready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
        end
        if (!out_ready) n_stall++;
        else begin
          acc_data.push_back(out_data);
          acc_idx.push_back(out_index);
          acc_last.push_back(out_last);
        end
        if (int'(out_index) == wr_idx) regs[wr_idx] = wr_val;
      end else begin
        out_ready = 1'($urandom_range(0, 1));
      end
      pv = out_valid; pr = out_ready; pd = out_data; pi = out_index; pl = out_last;
      start = (spam_start && !done) ? 1'($urandom_range(0, 1)) : 1'b0;
      step();
    end
    start = 1'b0;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    clear = 1'b1;
    repeat (3) step();
    checks++;
    if ({reg_sel, out_data, out_index, out_valid, out_last, busy, done} !== '0)
      begin failures++; $display("FAIL reset_outputs: got sel=%0d data=%h idx=%0d v=%b l=%b busy=%b done=%b, want all 0",
                                 reg_sel, out_data, out_index, out_valid, out_last, busy, done); end
    clear = 1'b0;
    for (int c = 0; c < 10; c++) begin
      step();
      checks++;
      if (busy !== 1'b0 || out_valid !== 1'b0 || done !== 1'b0)
        begin failures++; $display("FAIL idle_cycle%0d: got busy=%b valid=%b done=%b, want 0 0 0", c, busy, out_valid, done); end
    end
  endtask

  task automatic test_full_dump();
    for (int i = 0; i < NR; i++) regs[i] = 32'h1000 + i;
    run_pass(-1, 0, 1'b0, -1, '0, 1'b0);
    checks++;
    if (timed_out) begin failures++; $display("FAIL full_timeout: got no done within budget, want done"); end
    checks++;
    if (acc_data.size() != NR) begin failures++; $display("FAIL full_count: got %0d words, want %0d", acc_data.size(), NR); end
    for (int k = 0; k < acc_data.size() && k < NR; k++) begin
      checks++;
      if (acc_idx[k] !== SW'(k) || acc_data[k] !== 32'h1000 + k || acc_last[k] !== (k == NR - 1))
        begin failures++; $display("FAIL full_word%0d: got idx=%0d data=%h last=%b, want idx=%0d data=%h last=%b",
                                   k, acc_idx[k], acc_data[k], acc_last[k], k, 32'h1000 + k, (k == NR - 1)); end
    end
    checks++;
    if (done_at != 2 * NR) begin failures++; $display("FAIL full_done_cycle: got %0d, want %0d", done_at, 2 * NR); end
    checks++;
    if (n_done != 1) begin failures++; $display("FAIL full_done_pulses: got %0d, want 1", n_done); end
    checks++;
    if (n_busy_low != 0 || busy_after != 0)
      begin failures++; $display("FAIL full_busy: got low_during=%0d after=%0d, want 0 0", n_busy_low, busy_after); end
  endtask

  task automatic test_backpressure();
    for (int i = 0; i < NR; i++) regs[i] = 32'h1000 + i;
    run_pass(3, 5, 1'b0, -1, '0, 1'b0);
    checks++;
    if (n_stall != 5 || n_unstable != 0)
      begin failures++; $display("FAIL bp_hold: got stalls=%0d unstable=%0d, want 5 0", n_stall, n_unstable); end
    checks++;
    if (acc_data.size() != NR) begin failures++; $display("FAIL bp_count: got %0d words, want %0d", acc_data.size(), NR); end
    for (int k = 0; k < acc_data.size() && k < NR; k++) begin
      checks++;
      if (acc_idx[k] !== SW'(k) || acc_data[k] !== 32'h1000 + k)
        begin failures++; $display("FAIL bp_word%0d: got idx=%0d data=%h, want idx=%0d data=%h",
                                   k, acc_idx[k], acc_data[k], k, 32'h1000 + k); end
    end
    checks++;
    if (done_at != 2 * NR + 5 || n_done != 1)
      begin failures++; $display("FAIL bp_done: got cycle=%0d pulses=%0d, want %0d 1", done_at, n_done, 2 * NR + 5); end
  endtask

  task automatic test_write_during_hold();
    for (int i = 0; i < NR; i++) regs[i] = 32'h1000 + i;
    run_pass(2, 3, 1'b0, 2, 32'hDEAD, 1'b0);
    checks++;
    if (acc_data.size() < 3 || acc_data[2] !== 32'h1002)
      begin failures++; $display("FAIL wr_held_word: got %h (n=%0d), want %h", acc_data.size() > 2 ? acc_data[2] : 'x, acc_data.size(), 32'h1002); end
    checks++;
    if (n_unstable != 0 || done_at != 2 * NR + 3)
      begin failures++; $display("FAIL wr_hold_timing: got unstable=%0d done_at=%0d, want 0 %0d", n_unstable, done_at, 2 * NR + 3); end
    run_pass(-1, 0, 1'b0, -1, '0, 1'b0);
    checks++;
    if (acc_data.size() < 3 || acc_data[2] !== 32'hDEAD)
      begin failures++; $display("FAIL wr_rerun_word: got %h (n=%0d), want %h", acc_data.size() > 2 ? acc_data[2] : 'x, acc_data.size(), 32'hDEAD); end
  endtask

  // Random data, random readiness and start spam while busy (must be ignored)
  task automatic test_random_stream();
    for (int p = 0; p < 3; p++) begin
      for (int i = 0; i < NR; i++) regs[i] = $urandom;
      run_pass(-1, 0, 1'b1, -1, '0, 1'b1);
      checks++;
      if (acc_data.size() != NR || timed_out)
        begin failures++; $display("FAIL rnd%0d_count: got %0d words timeout=%0b, want %0d 0", p, acc_data.size(), timed_out, NR); end
      for (int k = 0; k < acc_data.size() && k < NR; k++) begin
        checks++;
        if (acc_idx[k] !== SW'(k) || acc_data[k] !== snap[k] || acc_last[k] !== (k == NR - 1))
          begin failures++; $display("FAIL rnd%0d_word%0d: got idx=%0d data=%h last=%b, want idx=%0d data=%h last=%b",
                                     p, k, acc_idx[k], acc_data[k], acc_last[k], k, snap[k], (k == NR - 1)); end
      end
      checks++;
      if (done_at != 2 * NR + n_stall || n_done != 1 || n_unstable != 0 || busy_after != 0)
        begin failures++; $display("FAIL rnd%0d_timing: got done_at=%0d pulses=%0d unstable=%0d busy_after=%0d, want %0d 1 0 0",
                                   p, done_at, n_done, n_unstable, busy_after, 2 * NR + n_stall); end
    end
  endtask

  task automatic test_abort();
    int found;
    int got_done;
    for (int i = 0; i < NR; i++) regs[i] = 32'h1000 + i;
    start = 1'b1; abort = 1'b0; out_ready = 1'b1;
    step();
    start = 1'b0;
    found = 0;
    for (int g = 0; g < 100; g++) begin
      if (out_valid && out_index == SW'(7)) begin found = 1; break; end
      step();
    end
    checks++;
    if (found == 0) begin failures++; $display("FAIL abort_reach7: got no word 7 within budget, want word 7"); end
    abort = 1'b1; out_ready = 1'b1;
    step();
    abort = 1'b0;
    checks++;
    if ({out_valid, out_last, busy, done} !== 4'b0000)
      begin failures++; $display("FAIL abort_idle: got valid=%b last=%b busy=%b done=%b, want 0 0 0 0", out_valid, out_last, busy, done); end
    checks++;
    if (reg_sel !== '0) begin failures++; $display("FAIL abort_sel: got %0d, want 0", reg_sel); end
    for (int c = 0; c < 3; c++) begin
      step();
      checks++;
      if (done !== 1'b0 || busy !== 1'b0)
        begin failures++; $display("FAIL abort_after%0d: got done=%b busy=%b, want 0 0", c, done, busy); end
    end
    // start and abort together while idle: start must win
    start = 1'b1; abort = 1'b1;
    step();
    start = 1'b0; abort = 1'b0;
    checks++;
    if (busy !== 1'b1 || reg_sel !== '0 || out_valid !== 1'b0)
      begin failures++; $display("FAIL restart_read: got busy=%b sel=%0d valid=%b, want 1 0 0", busy, reg_sel, out_valid); end
    step();
    checks++;
    if (out_valid !== 1'b1 || out_index !== '0 || out_data !== 32'h1000 || out_last !== 1'b0)
      begin failures++; $display("FAIL restart_word0: got valid=%b idx=%0d data=%h last=%b, want 1 0 00001000 0",
                                 out_valid, out_index, out_data, out_last); end
    got_done = 0;
    for (int g = 0; g < 200; g++) begin
      if (done) begin got_done = 1; break; end
      step();
    end
    checks++;
    if (got_done == 0) begin failures++; $display("FAIL restart_done: got no done within budget, want done"); end
    step();
    out_ready = 1'b0;
  endtask

  task automatic test_clear_mid_pass();
    int found;
    for (int i = 0; i < NR; i++) regs[i] = 32'h1000 + i;
    start = 1'b1; abort = 1'b0; out_ready = 1'b1;
    step();
    found = 0;
    for (int g = 0; g < 100; g++) begin
      start = 1'b1;  // repeated start while busy is ignored
      if (out_valid && out_index == SW'(9)) begin found = 1; break; end
      step();
    end
    start = 1'b0;
    checks++;
    if (found == 0) begin failures++; $display("FAIL clear_reach9: got no word 9 within budget, want word 9"); end
    #3 clear = 1'b1;
    #1;
    checks++;
    if ({reg_sel, out_data, out_index, out_valid, out_last, busy, done} !== '0)
      begin failures++; $display("FAIL clear_async: got sel=%0d data=%h idx=%0d v=%b l=%b busy=%b done=%b, want all 0",
                                 reg_sel, out_data, out_index, out_valid, out_last, busy, done); end
    @(posedge clock);
    #1;
    clear = 1'b0;
    for (int c = 0; c < 6; c++) begin
      step();
      checks++;
      if (busy !== 1'b0 || done !== 1'b0 || out_valid !== 1'b0)
        begin failures++; $display("FAIL clear_after%0d: got busy=%b done=%b valid=%b, want 0 0 0", c, busy, done, out_valid); end
    end
    out_ready = 1'b0;
  endtask

  initial begin
    clear = 1'b1; start = 1'b0; abort = 1'b0; out_ready = 1'b0;
    for (int i = 0; i < NR; i++) regs[i] = '0;
    test_reset();
    test_full_dump();
    test_backpressure();
    test_write_during_hold();
    test_random_stream();
    test_abort();
    test_clear_mid_pass();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
